// File: rtl/muldiv_unit_if.sv
// ============================================================================
// muldiv_unit_if : request/result bundle between execute stage and muldiv_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] rs_data_i;
  logic [WIDTH-1:0] rt_data_i;
  logic             busy_o;
  logic             done_o;
  logic             div_by_zero_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, rs_data_i, rt_data_i,
    input  busy_o, done_o, div_by_zero_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, rs_data_i, rt_data_i,
    output busy_o, done_o, div_by_zero_o, hi_o, lo_o
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative shift-add multiplier / restoring divider owning HI/LO
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   rs_raw_q, rs_raw_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_pulse_q, dbz_pulse_d;

  logic               op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fixed;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [WIDTH-1:0]   quo_fixed, rem_fixed;

  always_comb begin
    op_signed = (bus.op_i == OP_MULT) || (bus.op_i == OP_DIV);
    a_neg     = op_signed && bus.rs_data_i[WIDTH-1];
    b_neg     = op_signed && bus.rt_data_i[WIDTH-1];
    a_abs     = a_neg ? -bus.rs_data_i : bus.rs_data_i;
    b_abs     = b_neg ? -bus.rt_data_i : bus.rt_data_i;

    // Multiply: acc = {partial product high, remaining multiplier bits}
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits shifting out as quotient bits shift in}.
    // The remainder stays below the divisor, so WIDTH bits hold it between steps.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!div_diff[WIDTH])
      div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      div_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

    prod_fixed = neg_res_q ? -acc_q : acc_q;
    quo_fixed  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fixed  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    rs_raw_d    = rs_raw_q;
    is_div_d    = is_div_q;
    neg_res_d   = neg_res_q;
    neg_rem_d   = neg_rem_q;
    dbz_d       = dbz_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    done_d      = 1'b0;
    dbz_pulse_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          case (bus.op_i)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d   = S_CALC;
              cnt_d     = CW'(WIDTH - 1);
              is_div_d  = bus.op_i[1];
              neg_res_d = a_neg ^ b_neg;
              neg_rem_d = a_neg;
              rs_raw_d  = bus.rs_data_i;
              dbz_d     = bus.op_i[1] && (bus.rt_data_i == '0);
              if (bus.op_i[1]) begin
                acc_d  = {{WIDTH{1'b0}}, a_abs};
                opnd_d = b_abs;
              end else begin
                acc_d  = {{WIDTH{1'b0}}, b_abs};
                opnd_d = a_abs;
              end
            end
            OP_MTHI: hi_d = bus.rs_data_i;
            OP_MTLO: lo_d = bus.rs_data_i;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        if (cnt_q == '0)
          state_d = S_FIX;
        else
          cnt_d = cnt_q - 1'b1;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fixed[2*WIDTH-1:WIDTH];
          lo_d = prod_fixed[WIDTH-1:0];
        end else if (dbz_q) begin
          hi_d        = rs_raw_q;
          lo_d        = '1;
          dbz_pulse_d = 1'b1;
        end else begin
          hi_d = rem_fixed;
          lo_d = quo_fixed;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      rs_raw_q    <= '0;
      is_div_q    <= 1'b0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      done_q      <= 1'b0;
      dbz_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      rs_raw_q    <= rs_raw_d;
      is_div_q    <= is_div_d;
      neg_res_q   <= neg_res_d;
      neg_rem_q   <= neg_rem_d;
      dbz_q       <= dbz_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      done_q      <= done_d;
      dbz_pulse_q <= dbz_pulse_d;
    end
  end

  assign bus.busy_o        = (state_q != S_IDLE);
  assign bus.done_o        = done_q;
  assign bus.div_by_zero_o = dbz_pulse_q;
  assign bus.hi_o          = hi_q;
  assign bus.lo_o          = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// tb_muldiv_unit : directed vectors with a done-triggered scoreboard monitor
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk;
  logic reset_n;
  int   compared;
  int   mismatched;
  exp_t sb_q[$];

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done_o pulse retires the oldest expected result
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus.done_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("hi", bus.hi_o, e.hi);
          check("lo", bus.lo_o, e.lo);
          check("div_by_zero", {31'd0, bus.div_by_zero_o}, {31'd0, e.dbz});
        end
      end else if (bus.div_by_zero_o === 1'b1) begin
        check("dbz_without_done", 32'd1, 32'd0);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.rs_data_i = rs;
    bus.rt_data_i = rt;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (bus.busy_o === 1'b1 && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic run_md(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    int cyc;
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dbz = edbz;
    sb_q.push_back(e);
    issue(op, rs, rt);
    check("busy_after_accept", {31'd0, bus.busy_o}, 32'd1);
    wait_idle(cyc);
    check("busy_cycles", cyc, 32'd33);
  endtask

  initial begin
    int cyc;
    compared      = 0;
    mismatched    = 0;
    reset_n       = 1'b0;
    bus.start_i   = 1'b0;
    bus.op_i      = 3'b000;
    bus.rs_data_i = '0;
    bus.rt_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_done", {31'd0, bus.done_o}, 32'd0);
    check("rst_dbz",  {31'd0, bus.div_by_zero_o}, 32'd0);
    check("rst_hi",   bus.hi_o, 32'd0);
    check("rst_lo",   bus.lo_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Multiply vectors
    run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_md(OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_md(OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_md(OP_MULT,  32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);

    // Divide vectors, including the signed-overflow corner
    run_md(OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_md(OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_md(OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
    run_md(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    run_md(OP_DIVU, 32'hFFFF_FFFF, 32'd16,        32'd15,        32'h0FFF_FFFF, 1'b0);

    // Divide by zero: HI gets the raw dividend
    run_md(OP_DIV,  32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    run_md(OP_DIV,  32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);

    // MTHI / MTLO in IDLE
    issue(OP_MTHI, 32'hA5A5_A5A5, 32'd0);
    check("mthi_hi",   bus.hi_o, 32'hA5A5_A5A5);
    check("mthi_busy", {31'd0, bus.busy_o}, 32'd0);
    issue(OP_MTLO, 32'h0000_005A, 32'd0);
    check("mtlo_lo",   bus.lo_o, 32'h0000_005A);
    check("mtlo_hi",   bus.hi_o, 32'hA5A5_A5A5);
    @(negedge clk);
    check("mt_no_done", {31'd0, bus.done_o}, 32'd0);

    // MTLO while a MULT is in flight must be dropped
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'd42; e.dbz = 1'b0;
      sb_q.push_back(e);
    end
    issue(OP_MULT, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    issue(OP_MTLO, 32'h0000_0001, 32'd0);
    check("calc_lo_held", bus.lo_o, 32'h0000_005A);
    check("calc_hi_held", bus.hi_o, 32'hA5A5_A5A5);
    wait_idle(cyc);

    // Asynchronous reset in the middle of CALC
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd3);
    repeat (10) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("async_rst_hi",   bus.hi_o, 32'd0);
    check("async_rst_lo",   bus.lo_o, 32'd0);
    check("async_rst_done", {31'd0, bus.done_o}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_md(OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", compared);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair.
- Executes the MULT, MULTU, DIV and DIVU requests produced by the instruction decoder, plus the MTHI and MTLO writes.
- Supplies HI/LO read data for MFHI and MFLO.
- Sits beside the ALU in the execute stage. Stalls the pipeline through busy_o while an iterative operation runs.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start_i  input  1  request strobe, sampled on the rising edge.
op_i  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
rs_data_i  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
rt_data_i  input  WIDTH  rt operand: multiplier or divisor.
busy_o  output  1  high while an iterative operation is in flight.
done_o  output  1  one-cycle pulse when HI/LO receive a mult/div result.
div_by_zero_o  output  1  one-cycle pulse, coincident with done_o, for DIV/DIVU with rt==0.
hi_o  output  WIDTH  current HI register.
lo_o  output  WIDTH  current LO register.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low via reset_n.
- Reset: while reset_n is low, all state clears immediately.
  - State returns to IDLE.
  - hi_o=0, lo_o=0, busy_o=0, done_o=0, div_by_zero_o=0; counter and internal registers cleared.
  - Reset mid-operation aborts the operation. No result is written.
- States: IDLE, CALC, FIX.
- IDLE, request accept:
  - A request is accepted at rising edge E0 when start_i=1 and busy_o=0.
  - MTHI/MTLO: HI (or LO) takes rs_data_i at E0. State stays IDLE; no busy_o, no done_o.
  - MULT/MULTU/DIV/DIVU: go to CALC. busy_o=1 from E0.
  - For signed ops (MULT, DIV), latch absolute values of both operands. Record the result sign (rs_sign XOR rt_sign) and the dividend sign.
  - Load the iteration counter with WIDTH-1.
  - Reserved op_i: ignored, no state change.
- CALC: exactly WIDTH iterations, edges E1..E32 at WIDTH=32. The counter decrements every cycle; leave CALC when it reaches 0.
  - Multiply: shift-add on a 2*WIDTH-bit accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring algorithm, one quotient bit per cycle. Trial subtract on a WIDTH+1-bit partial remainder.
- FIX, at edge E33:
  - Apply sign correction, then write HI/LO. Go to IDLE.
  - busy_o=0 and done_o=1 for the cycle after E33. Total latency is WIDTH+1 edges after accept.
- Result rules:
  - MULT/MULTU: {HI,LO} = 64-bit product. Signed product is negated when the result sign is set.
  - DIV/DIVU: LO = quotient, truncated toward zero; HI = remainder.
  - DIV signs: quotient is negated when operand signs differ; remainder takes the sign of the dividend.
  - Signed -2^31 / -1: LO=0x80000000, HI=0; no flag.
- Divide by zero:
  - rt_data_i==0 is detected at accept. Full latency is still spent.
  - In FIX: HI = rs_data_i as latched (raw, unsigned view); LO = all ones; div_by_zero_o pulses with done_o.
- start_i while busy_o=1: ignored, not queued. The requester must hold off.
- Read path: hi_o and lo_o are registered outputs. HI/LO keep their old values during CALC; they are updated only in FIX or by MTHI/MTLO.
- done_o and div_by_zero_o are never high outside the single post-FIX cycle.

Test Plan:
1. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> busy_o high for 33 cycles; done_o pulse; HI=0xFFFFFFFE, LO=0x00000001.
2. MULT rs=0xFFFFFFFD (-3), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
3. DIVU 100/7 -> LO=14, HI=2. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
4. DIV rs=0x12345678, rt=0 -> after 33 cycles HI=0x12345678, LO=0xFFFFFFFF; div_by_zero_o and done_o high for one cycle together.
5. MTHI 0xA5A5A5A5 in IDLE -> hi_o updates next edge, no busy/done. During a MULT, pulse start_i with MTLO 0x1 -> ignored; final LO equals the product only.
6. Assert reset_n low at CALC iteration 10 -> busy_o, hi_o, lo_o go to 0 immediately (no clock). After release, DIVU 9/3 -> LO=3, HI=0, done_o after 33 cycles.
